// File: rtl/text_console_ctrl_pkg.sv
// Shared constants, FSM state type and address helper for the text console controller.
package text_console_pkg;

    localparam int unsigned COLS    = 32;
    localparam int unsigned ROWS    = 16;
    localparam int unsigned COL_W   = 5;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned OFFS_W  = 16;

    localparam logic [CHAR_W-1:0] CHAR_LF = 8'h0A;
    localparam logic [CHAR_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [CHAR_W-1:0] CHAR_BS = 8'h08;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_e;

    // Text-buffer address of a logical cursor position, accounting for the scroll origin.
    function automatic logic [ADDR_W-1:0] text_addr(input logic [ROW_W-1:0] top_row,
                                                    input logic [ROW_W-1:0] cur_row,
                                                    input logic [COL_W-1:0] col);
        logic [ROW_W-1:0] phys_row;
        phys_row = top_row + cur_row;
        return {phys_row, col};
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character-input and text-buffer write bundle for the text console controller.
interface text_console_ctrl_if;
    import text_console_pkg::*;

    logic [CHAR_W-1:0] ch;
    logic              ch_valid;
    logic              ch_ready;
    logic              clear;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic [OFFS_W-1:0] offset_y;
    logic              busy;

    modport master (
        output ch, ch_valid, clear,
        input  ch_ready, wr_en, wr_addr, wr_data, offset_y, busy
    );

    modport slave (
        input  ch, ch_valid, clear,
        output ch_ready, wr_en, wr_addr, wr_data, offset_y, busy
    );

endinterface

// File: rtl/text_console_ctrl.sv
// Text console controller: turns a character stream into text-buffer writes with scrolling and clears.
// Optional feature macro: TEXT_CONSOLE_BACKSPACE_EN (0x08 erases the previous cell instead of printing).
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic              i_pix_clk,
    input  logic              i_reset,
    input  logic [CHAR_W-1:0] i_char,
    input  logic              i_char_valid,
    output logic              o_char_ready,
    input  logic              i_clear,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [CHAR_W-1:0] o_wr_data,
    output logic [OFFS_W-1:0] o_offset_y,
    output logic              o_busy
);

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  top_q, top_d;
    logic              pend_q, pend_d;
    logic              scroll_q, scroll_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CHAR_W-1:0] wr_data_q, wr_data_d;
    logic              accept_c;
    logic              is_bs_c;

    assign o_char_ready = (state_q == IDLE) && !pend_q && !i_clear;
    assign accept_c     = i_char_valid && o_char_ready;

`ifdef TEXT_CONSOLE_BACKSPACE_EN
    assign is_bs_c = (i_char == CHAR_BS);
`else
    assign is_bs_c = 1'b0;
`endif

    always_ff @(posedge i_pix_clk or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: clears take priority over characters; a pending clear starts from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_clear || pend_q) state_d = CLEAR_ALL;
                else if (accept_c)     state_d = WRITE;
            end
            WRITE:     state_d = scroll_q ? CLEAR_ROW : IDLE;
            CLEAR_ROW: if (cnt_q[COL_W-1:0] == COL_W'(COLS - 1)) state_d = IDLE;
            CLEAR_ALL: if (cnt_q == ADDR_W'(COLS * ROWS - 1)) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Cursor/datapath update; write strobes are derived from the upcoming state so they align with it.
    always_comb begin
        logic adv;
        adv       = 1'b0;
        col_d     = col_q;
        row_d     = row_q;
        top_d     = top_q;
        pend_d    = pend_q;
        scroll_d  = scroll_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (state_d == CLEAR_ALL) begin
                    cnt_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = FILL_CHAR;
                end else if (accept_c) begin
                    scroll_d = 1'b0;
                    if (i_char == CHAR_CR) begin
                        col_d = '0;
                    end else if (i_char == CHAR_LF) begin
                        col_d = '0;
                        adv   = 1'b1;
                    end else if (is_bs_c) begin
                        if (col_q != '0) begin
                            col_d     = col_q - 5'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = text_addr(top_q, row_q, col_q - 5'd1);
                            wr_data_d = FILL_CHAR;
                        end else if (row_q != '0) begin
                            col_d     = COL_W'(COLS - 1);
                            row_d     = row_q - 4'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = text_addr(top_q, row_q - 4'd1, COL_W'(COLS - 1));
                            wr_data_d = FILL_CHAR;
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = text_addr(top_q, row_q, col_q);
                        wr_data_d = i_char;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d = '0;
                            adv   = 1'b1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end

                    // At the bottom row the view scrolls and the newly exposed row gets wiped.
                    if (adv) begin
                        if (row_q != ROW_W'(ROWS - 1)) begin
                            row_d = row_q + 4'd1;
                        end else begin
                            top_d    = top_q + 4'd1;
                            scroll_d = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                scroll_d = 1'b0;
                if (state_d == CLEAR_ROW) begin
                    cnt_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = text_addr(top_q, row_q, '0);
                    wr_data_d = FILL_CHAR;
                end
            end
            CLEAR_ROW: begin
                if (state_d == CLEAR_ROW) begin
                    cnt_d     = cnt_q + 9'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = text_addr(top_q, row_q, cnt_d[COL_W-1:0]);
                    wr_data_d = FILL_CHAR;
                end
            end
            CLEAR_ALL: begin
                if (state_d == CLEAR_ALL) begin
                    cnt_d     = cnt_q + 9'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_d;
                    wr_data_d = FILL_CHAR;
                end else begin
                    col_d  = '0;
                    row_d  = '0;
                    top_d  = '0;
                    pend_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (i_clear && (state_q != IDLE)) pend_d = 1'b1;
    end

    always_ff @(posedge i_pix_clk or posedge i_reset) begin
        if (i_reset) begin
            col_q     <= '0;
            row_q     <= '0;
            top_q     <= '0;
            pend_q    <= 1'b0;
            scroll_q  <= 1'b0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            top_q     <= top_d;
            pend_q    <= pend_d;
            scroll_q  <= scroll_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_offset_y = {9'b0, top_q, 3'b0};
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: random character streams against a screen-level model.
module tb_text_console_ctrl;
    import text_console_pkg::*;

    localparam logic [7:0] FILL = 8'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_console_ctrl_if bus ();

    text_console_ctrl #(.FILL_CHAR(FILL)) dut (
        .i_pix_clk    (clk),
        .i_reset      (rst),
        .i_char       (bus.ch),
        .i_char_valid (bus.ch_valid),
        .o_char_ready (bus.ch_ready),
        .i_clear      (bus.clear),
        .o_wr_en      (bus.wr_en),
        .o_wr_addr    (bus.wr_addr),
        .o_wr_data    (bus.wr_data),
        .o_offset_y   (bus.offset_y),
        .o_busy       (bus.busy)
    );

    int checks = 0;
    int failures = 0;
    int idle_viol = 0;
    logic [16:0] got[$];
    logic [16:0] exp_q[$];
    int m_col, m_row, m_top;

    // Capture every write strobe, and flag any strobe seen while the controller reports idle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got.push_back({bus.wr_addr, bus.wr_data});
            if (bus.busy !== 1'b1) idle_viol++;
        end
    end

    // ---------------- reference model: logical screen with a scroll origin ----------------
    function automatic int m_addr(input int r, input int c);
        return ((m_top + r) % 16) * 32 + c;
    endfunction

    function automatic void m_push(input int a, input logic [7:0] d);
        exp_q.push_back({9'(a), d});
    endfunction

    function automatic void m_newline();
        if (m_row < 15) m_row++;
        else begin
            m_top = (m_top + 1) % 16;
            for (int c = 0; c < 32; c++) m_push(m_addr(15, c), FILL);
        end
    endfunction

    function automatic void model_put(input logic [7:0] c);
        bit bs_feature;
`ifdef TEXT_CONSOLE_BACKSPACE_EN
        bs_feature = 1'b1;
`else
        bs_feature = 1'b0;
`endif
        if (c == 8'h0D) m_col = 0;
        else if (c == 8'h0A) begin m_col = 0; m_newline(); end
        else if (c == 8'h08 && bs_feature) begin
            if (m_col > 0) begin m_col--; m_push(m_addr(m_row, m_col), FILL); end
            else if (m_row > 0) begin m_row--; m_col = 31; m_push(m_addr(m_row, m_col), FILL); end
        end else begin
            m_push(m_addr(m_row, m_col), c);
            m_col++;
            if (m_col == 32) begin m_col = 0; m_newline(); end
        end
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < 512; a++) m_push(a, FILL);
        m_top = 0; m_row = 0; m_col = 0;
    endfunction

    // Index of the first strobe that differs from the model, or -1 when the sequences are identical.
    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        rst = 1'b1;
        bus.ch_valid = 1'b0;
        bus.clear = 1'b0;
        bus.ch = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0;
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        while (bus.ch_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL send_timeout: char_ready=%b still not high after %0d cycles", bus.ch_ready, n);
        end
        bus.ch = c;
        bus.ch_valid = 1'b1;
        @(posedge clk);
        #1 bus.ch_valid = 1'b0;
        model_put(c);
    endtask

    task automatic wait_idle();
        int n = 0, lows = 0;
        while (lows < 2 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b0) lows++; else lows = 0;
        end
        #1;
        if (lows < 2) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
    endtask

    function automatic logic [7:0] rand_printable();
        return 8'($urandom_range(8'h21, 8'h7E));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.ch_valid = 1'b0; bus.clear = 1'b0; bus.ch = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b, required 0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 9'd0) begin failures++; $display("FAIL reset_wr_addr: got %0d, required 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 8'd0) begin failures++; $display("FAIL reset_wr_data: got %h, required 00", bus.wr_data); end
        checks++; if (bus.offset_y !== 16'd0) begin failures++; $display("FAIL reset_offset_y: got %0d, required 0", bus.offset_y); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.ch_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", bus.ch_ready); end
        got.delete(); exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0;
    endtask

    task automatic test_single_char();
        apply_reset();
        @(negedge clk);
        bus.ch = 8'h41; bus.ch_valid = 1'b1;
        @(posedge clk);
        #1 bus.ch_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.ch_ready !== 1'b0) begin failures++; $display("FAIL single_ready_n1: got %b, required 0", bus.ch_ready); end
        @(negedge clk);
        checks++; if (bus.ch_ready !== 1'b1) begin failures++; $display("FAIL single_ready_n2: got %b, required 1", bus.ch_ready); end
        wait_idle();
        checks++;
        if (got.size() != 1 || got[0] !== {9'd0, 8'h41}) begin
            failures++;
            $display("FAIL single_strobe: got count=%0d first=%h, required count=1 first=%h", got.size(),
                     (got.size() > 0) ? got[0] : 17'h0, {9'd0, 8'h41});
        end
        send_char(8'h62);
        wait_idle();
        checks++;
        if (got.size() != 2 || got[got.size()-1] !== {9'd1, 8'h62}) begin
            failures++;
            $display("FAIL single_next_col: got count=%0d, required second strobe addr 1 data 62", got.size());
        end
    endtask

    task automatic test_row_wrap();
        int d;
        apply_reset();
        for (int i = 0; i < 33; i++) send_char(rand_printable());
        wait_idle();
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL row_wrap_seq: first difference at strobe %0d (got %0d strobes, required %0d)", d, got.size(), exp_q.size()); end
        checks++;
        if (got.size() != 33 || got[32][16:8] !== 9'd32) begin
            failures++;
            $display("FAIL row_wrap_33rd: got count=%0d, required 33 strobes with the last at addr 32", got.size());
        end
    endtask

    task automatic test_scroll();
        int strobes = 0, low_strobes = 0, d;
        apply_reset();
        for (int i = 0; i < 15; i++) send_char(8'h0A);
        wait_idle();
        checks++; if (bus.offset_y !== 16'd0) begin failures++; $display("FAIL scroll_pre_offset: got %0d, required 0", bus.offset_y); end
        send_char(8'h0A);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++; if (bus.offset_y !== 16'd8) begin failures++; $display("FAIL scroll_offset: got %0d, required 8", bus.offset_y); end
            end
            if (bus.wr_en === 1'b1) begin
                strobes++;
                if (bus.ch_ready === 1'b0) low_strobes++;
            end
        end
        wait_idle();
        checks++; if (strobes != 32 || low_strobes != 32) begin failures++; $display("FAIL scroll_ready_low: strobes=%0d with ready low=%0d, required 32/32", strobes, low_strobes); end
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL scroll_seq: first difference at strobe %0d (got %0d, required %0d)", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_clear_during_row();
        int d;
        got.delete(); exp_q.delete();
        send_char(8'h0A);
        repeat (5) @(negedge clk);
        pulse_clear();
        model_clear();
        wait_idle();
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL clr_row_seq: first difference at strobe %0d (got %0d, required %0d)", d, got.size(), exp_q.size()); end
        checks++; if (bus.offset_y !== 16'd0) begin failures++; $display("FAIL clr_row_offset: got %0d, required 0", bus.offset_y); end
        got.delete(); exp_q.delete();
        send_char(8'h42);
        wait_idle();
        checks++; if (got.size() != 1 || got[0] !== {9'd0, 8'h42}) begin failures++; $display("FAIL clr_row_cursor: got count=%0d, required one strobe addr 0 data 42", got.size()); end
    endtask

    task automatic test_clear_vs_char();
        int n = 0, d;
        apply_reset();
        for (int i = 0; i < 3; i++) send_char(rand_printable());
        wait_idle();
        got.delete(); exp_q.delete();
        @(negedge clk);
        bus.ch = 8'h43; bus.ch_valid = 1'b1; bus.clear = 1'b1;
        #1;
        checks++; if (bus.ch_ready !== 1'b0) begin failures++; $display("FAIL clr_vs_char_ready: got %b, required 0", bus.ch_ready); end
        @(posedge clk);
        #1 bus.clear = 1'b0;
        model_clear();
        @(negedge clk);
        while (bus.ch_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.ch_valid = 1'b0;
        model_put(8'h43);
        wait_idle();
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL clr_vs_char_seq: first difference at strobe %0d (got %0d, required %0d)", d, got.size(), exp_q.size()); end
        checks++; if (got.size() != 513 || got[512] !== {9'd0, 8'h43}) begin failures++; $display("FAIL clr_vs_char_late: got count=%0d, required 513 ending with addr 0 data 43", got.size()); end
    endtask

    task automatic test_reset_mid_clear();
        apply_reset();
        for (int i = 0; i < 20; i++) send_char(8'h0A);
        wait_idle();
        checks++; if (bus.offset_y !== 16'(m_top * 8)) begin failures++; $display("FAIL pre_abort_offset: got %0d, required %0d", bus.offset_y, m_top * 8); end
        pulse_clear();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.wr_addr !== 9'd0 || bus.offset_y !== 16'd0) begin
            failures++;
            $display("FAIL abort_clear: wr_en=%b busy=%b addr=%0d offset=%0d, required all 0", bus.wr_en, bus.busy, bus.wr_addr, bus.offset_y);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got.delete(); exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0;
        send_char(8'h5A);
        wait_idle();
        checks++; if (got.size() != 1 || got[0] !== {9'd0, 8'h5A}) begin failures++; $display("FAIL abort_restart: got count=%0d, required one strobe addr 0 data 5a", got.size()); end
    endtask

`ifdef TEXT_CONSOLE_BACKSPACE_EN
    task automatic test_backspace();
        apply_reset();
        send_char(8'h58);
        send_char(8'h08);
        wait_idle();
        checks++; if (got.size() != 2 || got[1] !== {9'd0, FILL}) begin failures++; $display("FAIL bs_erase: got count=%0d, required 2 strobes ending addr 0 data 20", got.size()); end
        send_char(8'h08);
        wait_idle();
        checks++; if (got.size() != 2) begin failures++; $display("FAIL bs_noop: got count=%0d, required 2", got.size()); end
        send_char(8'h51);
        wait_idle();
        checks++; if (got.size() != 3 || got[2] !== {9'd0, 8'h51}) begin failures++; $display("FAIL bs_cursor: got count=%0d, required third strobe addr 0 data 51", got.size()); end
    endtask
`endif

    task automatic test_random();
        int d, r;
        logic [7:0] c;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) c = 8'h0A;
            else if (r < 20) c = 8'h0D;
            else if (r < 27) c = 8'h08;
            else c = rand_printable();
            send_char(c);
            if ($urandom_range(0, 79) == 0) begin
                pulse_clear();
                model_clear();
            end
        end
        wait_idle();
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL random_seq: first difference at strobe %0d (got %0d, required %0d)", d, got.size(), exp_q.size()); end
        checks++; if (bus.offset_y !== 16'(m_top * 8)) begin failures++; $display("FAIL random_offset: got %0d, required %0d", bus.offset_y, m_top * 8); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ch = 8'h00; bus.ch_valid = 1'b0; bus.clear = 1'b0;
        test_reset();
        test_single_char();
        test_row_wrap();
        test_scroll();
        test_clear_during_row();
        test_clear_vs_char();
        test_reset_mid_clear();
`ifdef TEXT_CONSOLE_BACKSPACE_EN
        test_backspace();
`endif
        test_random();
        checks++; if (idle_viol != 0) begin failures++; $display("FAIL idle_write: got %0d strobes while idle, required 0", idle_viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter FILL_CHAR, default 8'h20, SHALL set the character written by row-clear and screen-clear.
REQ-003 i_pix_clk  input  1  SHALL be the clock; all logic SHALL be rising-edge.
REQ-004 i_reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_char  input  8  SHALL carry the incoming character code.
REQ-006 i_char_valid  input  1  SHALL mark i_char valid.
REQ-007 o_char_ready  output  1  SHALL be high when a character can be accepted.
REQ-008 i_clear  input  1  SHALL request a full-screen clear (single-cycle pulse).
REQ-009 o_wr_en  output  1  SHALL be the text-buffer write strobe.
REQ-010 o_wr_addr  output  9  SHALL be the text-buffer address {phys_row[3:0], col[4:0]}.
REQ-011 o_wr_data  output  8  SHALL be the text-buffer write data.
REQ-012 o_offset_y  output  16  SHALL be the tile-layer vertical scroll offset, {9'b0, top_row[3:0], 3'b0}.
REQ-013 o_busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-014 The grid SHALL be 32 columns by 16 rows; phys_row SHALL be (top_row + cur_row) mod 16.
REQ-015 The FSM SHALL have exactly the states IDLE, WRITE, CLEAR_ROW and CLEAR_ALL.
REQ-016 o_char_ready SHALL equal (state==IDLE) && !clear_pending && !i_clear.
REQ-017 A character SHALL be accepted only on a cycle with i_char_valid && o_char_ready.
REQ-018 A printable character (not 0x0A, 0x0D or 0x08) accepted in cycle N SHALL produce o_wr_en=1 in cycle N+1 with the cursor's address and o_wr_data=i_char, via state WRITE, returning to IDLE at N+2.
REQ-019 After a printable write, col SHALL increment; at col 31 it SHALL wrap to 0 and advance the row.
REQ-020 0x0D SHALL set col=0 with no write; it SHALL take one WRITE cycle with o_wr_en=0.
REQ-021 0x0A SHALL set col=0 and advance the row with no write.
REQ-022 Advancing the row with cur_row<15 SHALL increment cur_row.
REQ-023 Advancing the row at cur_row==15 SHALL hold cur_row at 15, increment top_row mod 16 and enter CLEAR_ROW.
REQ-024 CLEAR_ROW SHALL write FILL_CHAR to col 0..31 of the new phys_row, one per cycle (32 strobes), then return to IDLE.
REQ-025 o_offset_y SHALL update in the cycle top_row changes.
REQ-026 i_clear in IDLE SHALL win over a simultaneous valid character, which SHALL NOT be accepted.
REQ-027 i_clear outside IDLE SHALL set clear_pending; the pending clear SHALL start on the next IDLE cycle.
REQ-028 CLEAR_ALL SHALL write FILL_CHAR to addresses 0..511 in ascending order (512 strobes), then set top_row=0, cur_row=0, col=0, clear clear_pending and return to IDLE.
REQ-029 o_wr_en SHALL be low in IDLE.

Reset
REQ-030 On i_reset: state=IDLE, col=0, cur_row=0, top_row=0, clear_pending=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_offset_y=0, o_busy=0.
REQ-031 o_char_ready SHALL go high on the first cycle after reset deasserts.
REQ-032 Reset asserted mid-clear SHALL abort the clear immediately; partially written buffer contents are not restored.

Configuration
REQ-033 With TEXT_CONSOLE_BACKSPACE_EN defined, 0x08 SHALL move the cursor back one cell and write FILL_CHAR there; at col 0 it SHALL go to col 31 of the previous row, and at cur_row 0 / col 0 it SHALL be a no-op (WRITE cycle, o_wr_en=0).
REQ-034 Without TEXT_CONSOLE_BACKSPACE_EN, 0x08 SHALL be treated as a printable character.

Structure
REQ-035 Package text_console_pkg SHALL hold COLS=32, ROWS=16, CHAR_LF=8'h0A, CHAR_CR=8'h0D, CHAR_BS=8'h08 and the FSM state enum.
REQ-036 The module SHALL be flat with no sub-module; the clear counter SHALL be a 9-bit counter shared by CLEAR_ROW and CLEAR_ALL.

Verification
REQ-037 Reset, then send 'A' (0x41) -> exactly one strobe, addr 0, data 0x41; col=1; o_char_ready high again two cycles after acceptance.
REQ-038 Send 32 printable characters -> addresses 0..31; the 33rd character -> addr 32 (row 1, col 0).
REQ-039 Drive the cursor to row 15, then send 0x0A -> o_offset_y goes 0->8; 32 FILL_CHAR strobes at addr 0..31; o_char_ready low for those 32 cycles.
REQ-040 Pulse i_clear during CLEAR_ROW -> after CLEAR_ROW, 512 strobes at addr 0..511; o_offset_y=0; cursor at 0.
REQ-041 Assert i_clear and i_char_valid in the same IDLE cycle -> character not accepted; clear runs; character accepted afterwards at addr 0.
REQ-042 With TEXT_CONSOLE_BACKSPACE_EN defined: send 'X' then 0x08 -> strobe at addr 0 with 0x20; col=0; a second 0x08 produces no strobe.
